// File: rtl/mag_cmp_pkg.sv
// Shared types and helpers for the sequential magnitude comparator.
package mag_cmp_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // One-hot {gt, eq, lt} result encoding used by scoreboards.
  localparam logic [2:0] RES_GT = 3'b100;
  localparam logic [2:0] RES_EQ = 3'b010;
  localparam logic [2:0] RES_LT = 3'b001;

  // Number of DIGIT-wide digits in a WIDTH-bit operand.
  function automatic int num_digits(input int width, input int digit);
    return width / digit;
  endfunction

  // Digit counter width; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mag_comparator_seq_digit.sv
// Combinational DIGIT-bit magnitude comparator, MSB-first priority chain.
module mag_digit_cmp #(
  parameter int DIGIT = 2
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  output logic             gt,
  output logic             eq,
  output logic             lt
);

  // The first differing bit from the MSB decides; lower bits are ignored after that.
  always_comb begin
    logic g;
    logic l;
    g = 1'b0;
    l = 1'b0;
    for (int i = DIGIT - 1; i >= 0; i--) begin
      if (!g && !l) begin
        g = x[i] & ~y[i];
        l = ~x[i] & y[i];
      end
    end
    gt = g;
    lt = l;
    eq = ~(g | l);
  end

endmodule

// File: rtl/mag_comparator_seq.sv
// Multi-cycle magnitude comparator: walks operands MSB-first DIGIT bits per
// cycle, stops at the first differing digit, holds the gt/eq/lt result.
module mag_comparator_seq
  import mag_cmp_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             gt,
  output logic             eq,
  output logic             lt
);

  localparam int             N    = num_digits(WIDTH, DIGIT);
  localparam int             CW   = cnt_width(N);
  localparam logic [CW-1:0]  LAST = CW'(N - 1);

  state_t           state;
  logic [WIDTH-1:0] sh_a;
  logic [WIDTH-1:0] sh_b;
  logic [WIDTH-1:0] cap_a;
  logic [WIDTH-1:0] cap_b;
  logic [CW-1:0]    cnt;
  logic             d_gt;
  logic             d_eq;
  logic             d_lt;

  // Flipping the sign bit of both operands maps two's-complement order onto unsigned order.
  always_comb begin
    cap_a = a;
    cap_b = b;
    if (signed_mode) begin
      cap_a[WIDTH-1] = ~a[WIDTH-1];
      cap_b[WIDTH-1] = ~b[WIDTH-1];
    end
  end

  mag_digit_cmp #(.DIGIT(DIGIT)) u_digit (
    .x  (sh_a[WIDTH-1 -: DIGIT]),
    .y  (sh_b[WIDTH-1 -: DIGIT]),
    .gt (d_gt),
    .eq (d_eq),
    .lt (d_lt)
  );

  // Control FSM: capture on start in IDLE, one digit per cycle in RUN, early exit on difference.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      gt    <= 1'b0;
      eq    <= 1'b0;
      lt    <= 1'b0;
      cnt   <= '0;
      sh_a  <= '0;
      sh_b  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            sh_a  <= cap_a;
            sh_b  <= cap_b;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          if (!d_eq) begin
            gt    <= d_gt;
            lt    <= d_lt;
            eq    <= 1'b0;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end else if (cnt == LAST) begin
            gt    <= 1'b0;
            lt    <= 1'b0;
            eq    <= 1'b1;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            sh_a <= sh_a << DIGIT;
            sh_b <= sh_b << DIGIT;
            cnt  <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mag_comparator_seq.sv
// Randomized and directed bench for mag_comparator_seq against an arithmetic model.
module tb_mag_comparator_seq;
  import mag_cmp_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  int         cyc = 0;
  int         n_cmp = 0;
  int         n_err = 0;

  // WIDTH=8 DIGIT=2 instance
  logic       st8, sm8;
  logic [7:0] a8, b8;
  logic       busy8, done8, gt8, eq8, lt8;
  logic [2:0] prev8;
  int         t0_8;

  // WIDTH=4 instances, DIGIT=1 and DIGIT=4, sharing inputs
  logic       st4, sm4;
  logic [3:0] a4, b4;
  logic       busy41, done41, gt41, eq41, lt41;
  logic       busy44, done44, gt44, eq44, lt44;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mag_comparator_seq #(.WIDTH(8), .DIGIT(2)) dut8 (
    .clk(clk), .rst(rst), .start(st8), .signed_mode(sm8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .gt(gt8), .eq(eq8), .lt(lt8));

  mag_comparator_seq #(.WIDTH(4), .DIGIT(1)) dut41 (
    .clk(clk), .rst(rst), .start(st4), .signed_mode(sm4), .a(a4), .b(b4),
    .busy(busy41), .done(done41), .gt(gt41), .eq(eq41), .lt(lt41));

  mag_comparator_seq #(.WIDTH(4), .DIGIT(4)) dut44 (
    .clk(clk), .rst(rst), .start(st4), .signed_mode(sm4), .a(a4), .b(b4),
    .busy(busy44), .done(done44), .gt(gt44), .eq(eq44), .lt(lt44));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference: interpret operands as integers and compare.
  function automatic logic [2:0] ref_res(input int x, input int y, input int w, input bit s);
    int vx, vy;
    vx = x;
    vy = y;
    if (s) begin
      if (vx >= (1 << (w - 1))) vx -= (1 << w);
      if (vy >= (1 << (w - 1))) vy -= (1 << w);
    end
    if (vx > vy) return RES_GT;
    if (vx == vy) return RES_EQ;
    return RES_LT;
  endfunction

  // Reference latency: 1 + index (from MSB) of the first differing digit, N if equal.
  function automatic int ref_lat(input int x, input int y, input int w, input int d);
    int n;
    n = w / d;
    for (int j = 0; j < n; j++) begin
      if ((((x ^ y) >> (w - (j + 1) * d)) & ((1 << d) - 1)) != 0) return j + 1;
    end
    return n;
  endfunction

  // Drive start at a falling edge; returns at the falling edge after the capture edge.
  task automatic go8(input logic [7:0] x, input logic [7:0] y, input logic s);
    a8 = x; b8 = y; sm8 = s; st8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    st8 = 1'b0;
    t0_8 = cyc;
    chk("busy_run", busy8, 1);
    chk("done_run", done8, 0);
    chk("hold_prev", {gt8, eq8, lt8}, prev8);
  endtask

  // Wait for done, scrambling inputs meanwhile; checks flags and latency.
  task automatic wait8(input logic [7:0] x, input logic [7:0] y, input logic s, input string tag);
    logic [2:0] er;
    int         el;
    bit         got;
    er  = ref_res(x, y, 8, s);
    el  = ref_lat(x, y, 8, 2);
    got = 0;
    for (int k = 0; k < 12 && !got; k++) begin
      if (done8) got = 1;
      else begin
        a8 = 8'($urandom); b8 = 8'($urandom); sm8 = 1'($urandom);
        @(negedge clk);
      end
    end
    if (!got) chk({tag, "_timeout"}, 0, 1);
    else begin
      chk({tag, "_res"}, {gt8, eq8, lt8}, er);
      chk({tag, "_lat"}, cyc - t0_8, el);
      chk({tag, "_busy"}, busy8, 0);
    end
    prev8 = er;
  endtask

  task automatic cmp8(input logic [7:0] x, input logic [7:0] y, input logic s, input string tag);
    go8(x, y, s);
    wait8(x, y, s, tag);
    @(negedge clk);
    chk({tag, "_pulse"}, done8, 0);
    chk({tag, "_held"}, {gt8, eq8, lt8}, prev8);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    bit         seen;
    logic [7:0] x, y;
    int         lat41, lat44, t0;
    logic [2:0] r41, r44;
    bit         g41, g44;

    rst = 1'b1; st8 = 0; sm8 = 0; a8 = 0; b8 = 0; st4 = 0; sm4 = 0; a4 = 0; b4 = 0;
    prev8 = 3'b000;
    repeat (3) @(negedge clk);
    chk("rst8", {busy8, done8, gt8, eq8, lt8}, 0);
    chk("rst41", {busy41, done41, gt41, eq41, lt41}, 0);
    chk("rst44", {busy44, done44, gt44, eq44, lt44}, 0);
    rst = 1'b0;
    @(negedge clk);

    // Directed cases
    cmp8(8'hA5, 8'hA5, 1'b0, "eq_a5");
    cmp8(8'hC0, 8'h40, 1'b0, "u_c0_40");
    cmp8(8'hC0, 8'h40, 1'b1, "s_c0_40");
    cmp8(8'h80, 8'h7F, 1'b1, "s_80_7f");

    // Last-digit difference, then start during the done cycle
    go8(8'h12, 8'h13, 1'b0);
    wait8(8'h12, 8'h13, 1'b0, "last_dig");
    go8(8'hFF, 8'h00, 1'b0);
    wait8(8'hFF, 8'h00, 1'b0, "b2b");
    @(negedge clk);

    // start re-pulsed mid-run with different operands is ignored
    go8(8'hA5, 8'hA5, 1'b0);
    @(negedge clk);
    a8 = 8'h00; b8 = 8'hFF; sm8 = 1'b1; st8 = 1'b1;
    @(negedge clk);
    st8 = 1'b0;
    wait8(8'hA5, 8'hA5, 1'b0, "ign_start");
    @(negedge clk);

    // Reset mid-run aborts without a done pulse
    go8(8'hA5, 8'hA5, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_mid", {busy8, done8, gt8, eq8, lt8}, 0);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      seen |= done8;
    end
    chk("rst_nodone", seen, 0);
    prev8 = 3'b000;

    // Randomized 8-bit compares, biased toward long common prefixes
    repeat (40) begin
      x = 8'($urandom);
      case ($urandom_range(0, 3))
        0:       y = x;
        1:       y = x ^ 8'(1 << $urandom_range(0, 7));
        default: y = 8'($urandom);
      endcase
      cmp8(x, y, 1'($urandom), "rnd8");
    end

    // Exhaustive 4-bit sweep on both digit widths
    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < 16; i++) begin
        for (int j = 0; j < 16; j++) begin
          a4 = 4'(i); b4 = 4'(j); sm4 = 1'(s); st4 = 1'b1;
          @(posedge clk);
          @(negedge clk);
          st4 = 1'b0;
          t0 = cyc;
          g41 = 0; g44 = 0; lat41 = 0; lat44 = 0; r41 = 0; r44 = 0;
          for (int k = 0; k < 10 && !(g41 && g44); k++) begin
            if (done41 && !g41) begin g41 = 1; lat41 = cyc - t0; r41 = {gt41, eq41, lt41}; end
            if (done44 && !g44) begin g44 = 1; lat44 = cyc - t0; r44 = {gt44, eq44, lt44}; end
            if (!(g41 && g44)) @(negedge clk);
          end
          chk("sw41_res", r41, ref_res(i, j, 4, 1'(s)));
          chk("sw41_lat", lat41, ref_lat(i, j, 4, 1));
          chk("sw44_res", r44, ref_res(i, j, 4, 1'(s)));
          chk("sw44_lat", lat44, ref_lat(i, j, 4, 4));
        end
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
